// File: rtl/multi_arb.sv
// ---------------------------------------------------------------------------
// multi_arb
//
// Two-requester round-robin arbiter in front of a two-stage multiply pipeline.
// Each requester offers a signed register operand and a signed fixed-point
// immediate (3 fractional bits). The winning request is captured in stage S1.
// S1 computes reg * imm, rescales by 2^-3 (arithmetic shift, i.e. floor) and
// hands the low REG_WIDTH bits to S2, which drives the response port. Results
// wrap on overflow and are never saturated.
//
// Handshakes (both ports): a transfer happens on a rising clk edge exactly
// when valid and ready are both high in the cycle before that edge. A
// producer holding valid must keep its payload stable until the transfer.
// Here req_ready[i] is only ever raised for a requester whose req_valid[i]
// is high, and at most one bit of req_ready is high in any cycle.
//
// Ports:
//   clk        in   1            rising-edge clock
//   n_reset    in   1            asynchronous, active-low reset
//   req_valid  in   2            request valid, bit i = requester i
//   req_ready  out  2            request accepted this cycle (one-hot or 0)
//   req_reg    in   2*REG_WIDTH  signed register operand, req 0 in low half
//   req_imm    in   2*IMM_WIDTH  signed immediate (LSB = 2^-3), req 0 low
//   rsp_valid  out  1            result available (S2 valid)
//   rsp_ready  in   1            consumer accepts the result
//   rsp_id     out  1            requester that owns rsp_data
//   rsp_data   out  REG_WIDTH    signed result
//   busy       out  1            S1 or S2 holds a valid entry
// ---------------------------------------------------------------------------
module multi_arb #(
  parameter int REG_WIDTH = 8,
  parameter int IMM_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [2*REG_WIDTH-1:0]   req_reg,
  input  logic [2*IMM_WIDTH-1:0]   req_imm,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [REG_WIDTH-1:0]     rsp_data,
  output logic                     busy
);

  // Number of fractional bits carried by the immediate.
  localparam int FRAC_BITS = 3;
  localparam int PROD_WIDTH = REG_WIDTH + IMM_WIDTH;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic                  r_last_grant;

  logic                  r_s1_valid;
  logic                  r_s1_id;
  logic [REG_WIDTH-1:0]  r_s1_reg;
  logic [IMM_WIDTH-1:0]  r_s1_imm;

  logic                  r_s2_valid;
  logic                  r_s2_id;
  logic [REG_WIDTH-1:0]  r_s2_data;

  // -------------------------------------------------------------------------
  // Pipeline flow control
  // -------------------------------------------------------------------------
  logic w_s2_free;       // S2 may load this cycle (empty or draining)
  logic w_s1_advance;    // S1 entry moves into S2 this cycle
  logic w_s1_can_accept; // S1 will have room at the next edge

  assign w_s2_free       = ~r_s2_valid | rsp_ready;
  assign w_s1_advance    = r_s1_valid & w_s2_free;
  assign w_s1_can_accept = ~r_s1_valid | w_s1_advance;

  // -------------------------------------------------------------------------
  // Round-robin arbitration
  // -------------------------------------------------------------------------
  logic       w_grant_valid;
  logic       w_grant_id;
  logic       w_accept;

  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_id    = 1'b0;
    // n_reset gates the grant so req_ready stays low throughout reset even
    // though the emptied pipeline would otherwise have room.
    if (w_s1_can_accept && n_reset) begin
      case (req_valid)
        2'b01: begin
          w_grant_valid = 1'b1;
          w_grant_id    = 1'b0;
        end
        2'b10: begin
          w_grant_valid = 1'b1;
          w_grant_id    = 1'b1;
        end
        2'b11: begin
          // Contention: the requester that did not win last time goes now.
          w_grant_valid = 1'b1;
          w_grant_id    = ~r_last_grant;
        end
        default: begin
          w_grant_valid = 1'b0;
          w_grant_id    = 1'b0;
        end
      endcase
    end
  end

  assign w_accept  = w_grant_valid;
  assign req_ready = w_grant_valid ? (w_grant_id ? 2'b10 : 2'b01) : 2'b00;

  // Operand mux for the granted requester.
  logic [REG_WIDTH-1:0] w_sel_reg;
  logic [IMM_WIDTH-1:0] w_sel_imm;

  assign w_sel_reg = w_grant_id ? req_reg[2*REG_WIDTH-1:REG_WIDTH]
                                : req_reg[REG_WIDTH-1:0];
  assign w_sel_imm = w_grant_id ? req_imm[2*IMM_WIDTH-1:IMM_WIDTH]
                                : req_imm[IMM_WIDTH-1:0];

  // -------------------------------------------------------------------------
  // Arithmetic: full signed product, then drop the 3 fractional bits with an
  // arithmetic shift (floor toward -inf) and keep the low REG_WIDTH bits.
  // Both operands are sign-extended to the product width first so the
  // multiply is exactly PROD_WIDTH bits on both sides.
  // -------------------------------------------------------------------------
  logic signed [PROD_WIDTH-1:0] w_reg_ext;
  logic signed [PROD_WIDTH-1:0] w_imm_ext;
  logic signed [PROD_WIDTH-1:0] w_product;
  logic signed [PROD_WIDTH-1:0] w_scaled;
  logic [REG_WIDTH-1:0]         w_result;
  logic                         w_unused_bits;

  assign w_reg_ext = $signed({{IMM_WIDTH{r_s1_reg[REG_WIDTH-1]}}, r_s1_reg});
  assign w_imm_ext = $signed({{REG_WIDTH{r_s1_imm[IMM_WIDTH-1]}}, r_s1_imm});
  assign w_product = w_reg_ext * w_imm_ext;
  assign w_scaled  = w_product >>> FRAC_BITS;
  assign w_result  = w_scaled[REG_WIDTH-1:0];

  // Upper bits are discarded on purpose: the result wraps.
  assign w_unused_bits = ^w_scaled[PROD_WIDTH-1:REG_WIDTH];

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      // last_grant = 1 so requester 0 wins the first contention.
      r_last_grant <= 1'b1;
      r_s1_valid   <= 1'b0;
      r_s1_id      <= 1'b0;
      r_s1_reg     <= '0;
      r_s1_imm     <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_id      <= 1'b0;
      r_s2_data    <= '0;
    end else begin
      // S1: a new accept overwrites the slot; otherwise an entry that moved
      // on to S2 leaves S1 empty. With neither, S1 holds (stall).
      if (w_accept) begin
        r_s1_valid   <= 1'b1;
        r_s1_id      <= w_grant_id;
        r_s1_reg     <= w_sel_reg;
        r_s1_imm     <= w_sel_imm;
        r_last_grant <= w_grant_id;
      end else if (w_s1_advance) begin
        r_s1_valid   <= 1'b0;
      end

      // S2: reloads whenever it is empty or its result is being taken.
      // Payload is only written for a real entry so a bubble leaves the
      // previous data in place behind a low rsp_valid.
      if (w_s2_free) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_id   <= r_s1_id;
          r_s2_data <= w_result;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign rsp_valid = r_s2_valid;
  assign rsp_id    = r_s2_id;
  assign rsp_data  = r_s2_data;
  assign busy      = r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_multi_arb.sv
// ---------------------------------------------------------------------------
// tb_multi_arb
//
// Directed bench for multi_arb. Inputs are driven and outputs sampled 1 ns
// after each rising clk edge, so combinational req_ready is observed for the
// inputs of the current cycle and registered outputs reflect the last edge.
// ---------------------------------------------------------------------------
module tb_multi_arb;

  localparam int REG_WIDTH = 8;
  localparam int IMM_WIDTH = 5;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic n_reset = 1'b0;

  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // DUT
  // -------------------------------------------------------------------------
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [2*REG_WIDTH-1:0] req_reg;
  logic [2*IMM_WIDTH-1:0] req_imm;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_id;
  logic [REG_WIDTH-1:0]   rsp_data;
  logic                   busy;

  multi_arb #(
    .REG_WIDTH (REG_WIDTH),
    .IMM_WIDTH (IMM_WIDTH)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_reg   (req_reg),
    .req_imm   (req_imm),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // -------------------------------------------------------------------------
  // Scoreboard counters and helpers
  // -------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic [7:0] r, input logic [4:0] i);
    req_reg[7:0] = r;
    req_imm[4:0] = i;
  endtask

  task automatic set_req1(input logic [7:0] r, input logic [4:0] i);
    req_reg[15:8] = r;
    req_imm[9:5]  = i;
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    req_valid = 2'b11;
    req_reg   = '0;
    req_imm   = '0;
    rsp_ready = 1'b0;

    // ---- Reset values (requests offered during reset must not be taken)
    tick();
    tick();
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id",    rsp_id,    1'b0);
    check("rst_rsp_data",  rsp_data,  8'h00);
    check("rst_busy",      busy,      1'b0);
    req_valid = 2'b00;
    n_reset   = 1'b1;

    // ---- Single op: 16 * 1.0 = 16, two cycles to rsp_valid
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    set_req0(8'd16, 5'b01000);
    #1;
    check("single_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    check("single_lat1_valid", rsp_valid, 1'b0);
    check("single_lat1_busy",  busy,      1'b1);
    tick();
    check("single_valid", rsp_valid, 1'b1);
    check("single_id",    rsp_id,    1'b0);
    check("single_data",  rsp_data,  8'd16);
    tick();
    check("single_drained_valid", rsp_valid, 1'b0);
    check("single_drained_busy",  busy,      1'b0);

    // ---- Negative / wrap: -128 * -2.0 = 256 -> 0; -3 * 0.125 -> floor -1
    req_valid = 2'b01;
    set_req0(8'h80, 5'b10000);
    #1;
    check("wrap_ready0", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    set_req1(8'hFD, 5'b00001);
    #1;
    check("wrap_ready1", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    check("wrap_valid", rsp_valid, 1'b1);
    check("wrap_id",    rsp_id,    1'b0);
    check("wrap_data",  rsp_data,  8'h00);
    tick();
    check("floor_valid", rsp_valid, 1'b1);
    check("floor_id",    rsp_id,    1'b1);
    check("floor_data",  rsp_data,  8'hFF);
    tick();
    check("floor_drained", rsp_valid, 1'b0);

    // ---- Contention after a fresh reset: grants 0,1,0,1
    n_reset = 1'b0;
    #1;
    n_reset = 1'b1;
    set_req0(8'd1, 5'b01000);   // -> 1
    set_req1(8'd2, 5'b01000);   // -> 2
    req_valid = 2'b11;
    #1;
    check("cont_grant0", req_ready, 2'b01);
    tick();
    check("cont_grant1", req_ready, 2'b10);
    tick();
    check("cont_grant2", req_ready, 2'b01);
    check("cont_rsp0_id",   rsp_id,   1'b0);
    check("cont_rsp0_data", rsp_data, 8'd1);
    tick();
    check("cont_grant3", req_ready, 2'b10);
    check("cont_rsp1_id",   rsp_id,   1'b1);
    check("cont_rsp1_data", rsp_data, 8'd2);
    tick();
    req_valid = 2'b00;
    check("cont_rsp2_valid", rsp_valid, 1'b1);
    check("cont_rsp2_id",    rsp_id,    1'b0);
    tick();
    check("cont_rsp3_valid", rsp_valid, 1'b1);
    check("cont_rsp3_id",    rsp_id,    1'b1);
    tick();
    check("cont_drained", rsp_valid, 1'b0);

    // ---- Backpressure: three offered, two taken, third taken when S1 frees
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    set_req0(8'd10, 5'b01000);
    #1;
    check("bp_acc_a", req_ready, 2'b01);
    tick();
    set_req0(8'd20, 5'b01000);
    check("bp_acc_b", req_ready, 2'b01);
    tick();
    set_req0(8'd30, 5'b01000);
    check("bp_full_ready", req_ready, 2'b00);
    check("bp_full_valid", rsp_valid, 1'b1);
    check("bp_full_data",  rsp_data,  8'd10);
    tick();
    check("bp_hold_ready", req_ready, 2'b00);
    check("bp_hold_data",  rsp_data,  8'd10);
    check("bp_hold_id",    rsp_id,    1'b0);
    check("bp_hold_busy",  busy,      1'b1);
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", req_ready, 2'b01);
    check("bp_out_a", rsp_data, 8'd10);
    tick();
    req_valid = 2'b00;
    check("bp_out_b_valid", rsp_valid, 1'b1);
    check("bp_out_b", rsp_data, 8'd20);
    tick();
    check("bp_out_c_valid", rsp_valid, 1'b1);
    check("bp_out_c", rsp_data, 8'd30);
    tick();
    check("bp_drained", rsp_valid, 1'b0);

    // ---- Reset mid-flight with two entries in the pipe
    req_valid = 2'b01;
    set_req0(8'd5, 5'b01000);
    tick();
    set_req0(8'd6, 5'b01000);
    tick();
    req_valid = 2'b00;
    check("mid_pre_valid", rsp_valid, 1'b1);
    check("mid_pre_data",  rsp_data,  8'd5);
    n_reset = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_busy",  busy,      1'b0);
    check("mid_rst_data",  rsp_data,  8'h00);
    #1;
    n_reset = 1'b1;
    tick();
    check("mid_post1_valid", rsp_valid, 1'b0);
    check("mid_post1_busy",  busy,      1'b0);
    tick();
    check("mid_post2_valid", rsp_valid, 1'b0);

    // ---- Streaming: requester 1 alone for 10 cycles, data = i+1
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        req_valid = 2'b10;
        set_req1(8'(i + 1), 5'b01000);
        #1;
        check($sformatf("stream_ready_%0d", i), req_ready, 2'b10);
      end else begin
        req_valid = 2'b00;
      end
      tick();
      if (i >= 1 && i <= 10) begin
        check($sformatf("stream_valid_%0d", i), rsp_valid, 1'b1);
        check($sformatf("stream_id_%0d", i),    rsp_id,    1'b1);
        check($sformatf("stream_data_%0d", i),  rsp_data,  32'(i));
      end else if (i == 11) begin
        check("stream_drained", rsp_valid, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
